// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instruction,
    output logic [WORD_WIDTH-1:0] if_pc,
    output logic [WORD_WIDTH-1:0] if_instruction,
    output logic                  if_valid
);

    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_plus4;
    logic [WORD_WIDTH-1:0] branch_target;

    assign imem_addr     = pc;
    assign pc_plus4      = pc + WORD_WIDTH'(4);
    assign branch_target = {branch_addr[WORD_WIDTH-1:2], 2'b00};

    // A taken branch wins over freeze: the stalled fetch is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_target;
        end else if (!freeze) begin
            pc <= pc_plus4;
        end
    end

    // A bubble is the all-zero word with if_valid low, identical to reset.
    always_ff @(posedge clk) begin
        if (rst || flush || branch_taken) begin
            if_pc          <= '0;
            if_instruction <= '0;
            if_valid       <= 1'b0;
        end else if (!freeze) begin
            if_pc          <= pc_plus4;
            if_instruction <= imem_instruction;
            if_valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a small combinational
// instruction memory model.
module tb_fetch_stage;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         freeze;
    logic         flush;
    logic         branch_taken;
    logic [W-1:0] branch_addr;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_instruction;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_instruction;
    logic         if_valid;

    logic [W-1:0] mem [64];

    int checks;
    int failures;

    typedef struct {
        logic         rst;
        logic         freeze;
        logic         flush;
        logic         br;
        logic [W-1:0] br_addr;
        logic [W-1:0] exp_addr;
        logic [W-1:0] exp_if_pc;
        logic [W-1:0] exp_instr;
        logic         exp_valid;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    fetch_stage #(.WORD_WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .if_pc            (if_pc),
        .if_instruction   (if_instruction),
        .if_valid         (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Addresses at or above 0x100 lie outside the memory and read as zero.
    always_comb begin
        imem_instruction = '0;
        if (imem_addr < 32'h100)
            imem_instruction = mem[imem_addr[7:2]];
    end

    task automatic applyStimulus(input logic r, input logic fz, input logic fl,
                                 input logic br, input logic [W-1:0] ba);
        @(negedge clk);
        rst          = r;
        freeze       = fz;
        flush        = fl;
        branch_taken = br;
        branch_addr  = ba;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int step, input logic [W-1:0] ea,
                               input logic [W-1:0] ep, input logic [W-1:0] ei,
                               input logic ev);
        checkOne($sformatf("step%0d imem_addr", step), imem_addr, ea);
        checkOne($sformatf("step%0d if_pc", step), if_pc, ep);
        checkOne($sformatf("step%0d if_instruction", step), if_instruction, ei);
        checkOne($sformatf("step%0d if_valid", step), {31'b0, if_valid}, {31'b0, ev});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hE3A0_0000 + 32'(i);
        mem[0] = 32'hE3A0_0014;
        mem[1] = 32'hE3A0_1A01;

        rst          = 1'b1;
        freeze       = 1'b0;
        flush        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;

        //         rst   frz   fl    br    br_addr        addr           if_pc          instr          valid
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         32'h4,         32'hE3A00014,  1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,         32'h8,         32'hE3A01A01,  1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,         32'h8,         32'hE3A01A01,  1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,         32'h8,         32'hE3A01A01,  1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,         32'hC,         32'hE3A00002,  1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h43,       32'h40,        32'h0,         32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h44,        32'h44,        32'hE3A00010,  1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12,       32'h10,        32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h14,        32'h0,         32'h0,         1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h18,        32'h18,        32'hE3A00005,  1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h18,        32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1C,        32'h1C,        32'hE3A00006,  1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC,  32'h0,         32'h0,         1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         32'h4,         32'hE3A00014,  1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,         32'h8,         32'hE3A01A01,  1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h18,       32'h18,        32'h0,         32'h0,         1'b0};

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].freeze, vecs[i].flush,
                          vecs[i].br, vecs[i].br_addr);
            checkOutput(i, vecs[i].exp_addr, vecs[i].exp_if_pc,
                        vecs[i].exp_instr, vecs[i].exp_valid);
        end

        // Reset at pc=24 overrides freeze, flush and a simultaneous branch.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
        checkOutput(100, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput(101, 32'h4, 32'h4, 32'hE3A00014, 1'b1);

        // Freeze held for three cycles keeps everything stable, then fetch resumes.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput(200 + n, 32'h4, 32'h4, 32'hE3A00014, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput(210, 32'h8, 32'h8, 32'hE3A01A01, 1'b1);

        // Plain branch with no stall: one bubble, then the target word.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
        checkOutput(300, 32'h20, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput(301, 32'h24, 32'h24, 32'hE3A00008, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
